// File: rtl/decode_regfile_stage.sv
// Decode/operand-fetch stage for the SIMPLE 16-bit ISA: register file with write-back
// bypass, instruction-class decode and a registered decode bundle behind valid/ready.
module decode_regfile_stage #(
  parameter int DATA_W     = 16,
  parameter int NREGS      = 8,
  parameter int FORWARD    = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       command,
  input  logic [DATA_W-1:0] pc,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] alu1,
  output logic [DATA_W-1:0] alu2,
  output logic [3:0]        opcode,
  output logic              writereg,
  output logic [2:0]        regaddress,
  output logic [1:0]        memwrite,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] storedata
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DATA_W-1:0] regs [NREGS];
  logic              accept;
  logic [DATA_W-1:0] ra_p0, rb_p0, alu1_p0, alu2_p0, address_p0, storedata_p0;
  logic              writereg_p0;
  logic [2:0]        regaddress_p0;
  logic [1:0]        memwrite_p0;

  function automatic logic signed [DATA_W-1:0] sext8(input logic [7:0] x);
    return {{(DATA_W-8){x[7]}}, x};
  endfunction

  // Out-of-range indices read as zero and never see the bypass.
  function automatic logic [DATA_W-1:0] read_reg(input logic [2:0] idx);
    logic [DATA_W-1:0] val;
    val = '0;
    if (int'(idx) < NREGS) begin
      val = regs[idx[AW-1:0]];
      if (FORWARD != 0 && wb_en && wb_addr == idx) val = wb_data;
    end
    return val;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
    end else if (wb_en && int'(wb_addr) < NREGS) begin
      regs[wb_addr[AW-1:0]] <= wb_data;
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Stage p0: combinational decode and operand fetch
  always_comb begin
    ra_p0         = read_reg(command[13:11]);
    rb_p0         = read_reg(command[10:8]);
    alu1_p0       = ra_p0;
    alu2_p0       = rb_p0;
    writereg_p0   = 1'b1;
    regaddress_p0 = command[10:8];
    memwrite_p0   = 2'b00;
    address_p0    = '0;
    storedata_p0  = '0;
    case (command[15:14])
      2'd3: begin
        if (command[7:4] > 4'd8) alu2_p0 = {{(DATA_W-4){1'b0}}, command[3:0]};
      end
      2'd0: begin
        regaddress_p0 = command[13:11];
        memwrite_p0   = 2'b01;
        address_p0    = rb_p0 + $unsigned(sext8(command[7:0]));
      end
      2'd1: begin
        writereg_p0   = 1'b0;
        regaddress_p0 = 3'd0;
        memwrite_p0   = 2'b10;
        address_p0    = rb_p0 + $unsigned(sext8(command[7:0]));
        storedata_p0  = ra_p0;
      end
      default: begin
        alu1_p0     = '0;
        alu2_p0     = '0;
        memwrite_p0 = 2'b01;
        address_p0  = $unsigned(sext8(command[7:0]));
      end
    endcase
  end

  // Stage p1: registered decode bundle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      alu1       <= '0;
      alu2       <= '0;
      opcode     <= '0;
      writereg   <= 1'b0;
      regaddress <= '0;
      memwrite   <= '0;
      address    <= '0;
      storedata  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_pc     <= pc;
      alu1       <= alu1_p0;
      alu2       <= alu2_p0;
      opcode     <= command[7:4];
      writereg   <= writereg_p0;
      regaddress <= regaddress_p0;
      memwrite   <= memwrite_p0;
      address    <= address_p0;
      storedata  <= storedata_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_regfile_stage.sv
// Scoreboard bench for decode_regfile_stage: two configurations share one stimulus stream,
// each checked against a register-array reference model of the ISA decode rules.
module tb_decode_regfile_stage;
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] alu1;
    logic [15:0] alu2;
    logic [3:0]  opcode;
    logic        writereg;
    logic [2:0]  regaddress;
    logic [1:0]  memwrite;
    logic [15:0] address;
    logic [15:0] storedata;
  } bundle_t;
  typedef struct packed { bundle_t b0; bundle_t b1; } pair_t;

  logic        clock = 0, reset_n = 1, in_valid = 0, flush = 0, wb_en = 0, out_ready = 0;
  logic [15:0] command = 0, pc = 0, wb_data = 0;
  logic [2:0]  wb_addr = 0;
  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  bundle_t     act0, act1;

  int checks = 0, fails = 0;
  logic        mon_en = 0, mv = 0, have_pend = 0;
  pair_t       pend;
  pair_t       q[$];
  logic [15:0] m [2][8];

  always #5 clock = ~clock;

  // dut0: 8 regs with bypass; dut1: 4 regs, no bypass
  decode_regfile_stage #(.DATA_W(16), .NREGS(8), .FORWARD(1), .INIT_INDEX(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .command(command), .pc(pc), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid0), .out_ready(out_ready), .out_pc(act0.pc),
    .alu1(act0.alu1), .alu2(act0.alu2), .opcode(act0.opcode), .writereg(act0.writereg),
    .regaddress(act0.regaddress), .memwrite(act0.memwrite), .address(act0.address),
    .storedata(act0.storedata));

  decode_regfile_stage #(.DATA_W(16), .NREGS(4), .FORWARD(0), .INIT_INDEX(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .command(command), .pc(pc), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid1), .out_ready(out_ready), .out_pc(act1.pc),
    .alu1(act1.alu1), .alu2(act1.alu2), .opcode(act1.opcode), .writereg(act1.writereg),
    .regaddress(act1.regaddress), .memwrite(act1.memwrite), .address(act1.address),
    .storedata(act1.storedata));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nregs(input int d);
    return (d == 0) ? 8 : 4;
  endfunction

  task automatic init_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) m[d][i] = 16'(i);
  endtask

  function automatic logic [15:0] mread(input int d, input logic [2:0] idx, input logic we,
                                        input logic [2:0] wa, input logic [15:0] wd);
    if (int'(idx) >= nregs(d)) return 16'h0;
    if (d == 0 && we && wa == idx) return wd;
    return m[d][idx];
  endfunction

  function automatic bundle_t model(input int d, input logic [15:0] cmd, input logic [15:0] p,
                                    input logic we, input logic [2:0] wa, input logic [15:0] wd);
    bundle_t b;
    logic [15:0] ra, rb, off;
    b  = '0;
    ra = mread(d, cmd[13:11], we, wa, wd);
    rb = mread(d, cmd[10:8], we, wa, wd);
    off = {{8{cmd[7]}}, cmd[7:0]};
    b.pc = p;
    b.opcode = cmd[7:4];
    case (cmd[15:14])
      2'd3: begin
        b.alu1 = ra;
        b.alu2 = (cmd[7:4] <= 4'd8) ? rb : {12'h0, cmd[3:0]};
        b.writereg = 1; b.regaddress = cmd[10:8];
      end
      2'd0: begin
        b.alu1 = ra; b.alu2 = rb; b.writereg = 1; b.regaddress = cmd[13:11];
        b.memwrite = 2'b01; b.address = rb + off;
      end
      2'd1: begin
        b.alu1 = ra; b.alu2 = rb; b.memwrite = 2'b10;
        b.address = rb + off; b.storedata = ra;
      end
      default: begin
        b.writereg = 1; b.regaddress = cmd[10:8]; b.memwrite = 2'b01; b.address = off;
      end
    endcase
    return b;
  endfunction

  task automatic drive(input logic iv, input logic [15:0] cmd, input logic [15:0] p,
                       input logic fl, input logic we, input logic [2:0] wa,
                       input logic [15:0] wd, input logic ordy);
    logic acc;
    @(posedge clock);
    if (have_pend) begin q.push_back(pend); have_pend = 0; end
    #1;
    in_valid = iv; command = cmd; pc = p; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    #1;
    chk("in_ready0", in_ready0, !mv || ordy);
    chk("in_ready1", in_ready1, !mv || ordy);
    acc = iv && (!mv || ordy) && !fl;
    if (acc) begin
      pend.b0 = model(0, cmd, p, we, wa, wd);
      pend.b1 = model(1, cmd, p, we, wa, wd);
      have_pend = 1;
    end
    if (fl) mv = 0;
    else if (acc) mv = 1;
    else if (ordy) mv = 0;
    if (we)
      for (int d = 0; d < 2; d++) if (int'(wa) < nregs(d)) m[d][wa] = wd;
  endtask

  task automatic idle();
    drive(0, 16'h0, 16'h0, 0, 0, 3'd0, 16'h0, 1);
  endtask

  task automatic mid_reset();
    @(posedge clock);
    #1;
    have_pend = 0; in_valid = 0; flush = 0; wb_en = 0;
    reset_n = 0;
    #1;
    chk("rst_valid0", out_valid0, 0);
    chk("rst_valid1", out_valid1, 0);
    chk("rst_bundle0", act0, 0);
    chk("rst_bundle1", act1, 0);
    q.delete(); mv = 0; init_model();
    @(negedge clock);
    #1 reset_n = 1;
  endtask

  always @(negedge clock) begin
    if (reset_n && mon_en) begin
      logic exp_v;
      exp_v = (q.size() != 0);
      chk("out_valid0", out_valid0, exp_v);
      chk("out_valid1", out_valid1, exp_v);
      if (exp_v) begin
        chk("bundle0", act0, q[0].b0);
        chk("bundle1", act1, q[0].b1);
        if (out_ready || flush) void'(q.pop_front());
      end
    end
  end

  initial begin
    init_model();
    #1 reset_n = 0;
    #1;
    chk("reset_valid0", out_valid0, 0);
    chk("reset_valid1", out_valid1, 0);
    chk("reset_bundle0", act0, 0);
    chk("reset_bundle1", act1, 0);
    @(negedge clock);
    #1 reset_n = 1;
    mon_en = 1;

    drive(1, 16'hC260, 16'h0100, 0, 0, 3'd0, 16'h0, 1);
    drive(1, 16'h0BFE, 16'h0102, 0, 0, 3'd0, 16'h0, 1);
    drive(1, 16'h6A05, 16'h0104, 0, 1, 3'd2, 16'h1234, 1);
    idle();
    chk("st_addr_fwd", act0.address, 16'h1239);
    chk("st_addr_nofwd", act1.address, 16'h0007);

    // stall with in_valid held high, then release
    drive(1, 16'hC8A3, 16'h0200, 0, 0, 3'd0, 16'h0, 1);
    for (int i = 0; i < 3; i++) drive(1, 16'h8A7F, 16'h0202, 0, 1, 3'd3, 16'h5555, 0);
    drive(1, 16'h8A7F, 16'h0202, 0, 0, 3'd0, 16'h0, 1);
    // flush while holding
    drive(1, 16'h1981, 16'h0300, 0, 0, 3'd0, 16'h0, 0);
    drive(1, 16'hD1C4, 16'h0302, 1, 0, 3'd0, 16'h0, 0);
    idle();

    // out-of-range register in the 4-entry configuration
    drive(1, 16'hF000, 16'h0400, 0, 0, 3'd0, 16'h0, 1);
    drive(0, 16'h0, 16'h0, 0, 1, 3'd6, 16'hBEEF, 1);
    drive(1, 16'hF000, 16'h0402, 0, 0, 3'd0, 16'h0, 1);
    idle();
    chk("r6_read8", act0.alu1, 16'hBEEF);
    chk("r6_read4", act1.alu1, 16'h0000);

    drive(1, 16'hC260, 16'h0500, 0, 0, 3'd0, 16'h0, 0);
    mid_reset();

    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom),
            $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 3; i++) idle();
    @(posedge clock);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
